// File: rtl/pio_out_blink.sv
// Parallel output port with per-bit blink masking.
// Software writes DATA directly or via OUTSET/OUTCLEAR. Bits selected in
// BLINK_EN are gated by a free-running phase that toggles every PERIOD cycles.
// Bus handshake: a write happens on a clk edge where chipselect=1 and
// write_n=0; reads are zero-wait, decoded combinationally from address and
// qualified by chipselect. There is no back-pressure.
module pio_out_blink #(
  parameter int                 WIDTH       = 10,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    blink_q, blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  logic                wr_en;
  logic [WIDTH-1:0]    wr_bits;
  logic [PERIOD_W-1:0] wr_period;
  logic [PERIOD_W-1:0] period_last;
  logic                unused_writedata;

  assign wr_en       = chipselect & ~write_n;
  assign wr_bits     = writedata[WIDTH-1:0];
  assign wr_period   = writedata[PERIOD_W-1:0];
  // Terminal count is evaluated at PERIOD_W width; only used when PERIOD!=0.
  assign period_last = period_q - PERIOD_ONE;
  // Upper write-data bits are unused when both registers are narrower than 32.
  assign unused_writedata = ^writedata;

  // Next-state for the software-visible registers.
  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d   = wr_bits;
        ADDR_BLINK_EN: blink_d  = wr_bits;
        ADDR_PERIOD:   period_d = wr_period;
        ADDR_OUTSET:   data_d   = data_q | wr_bits;
        ADDR_OUTCLEAR: data_d   = data_q & ~wr_bits;
        default:       ;
      endcase
    end
  end

  // Next-state for the blink counter and phase; a PERIOD write restarts the on-phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (address == ADDR_PERIOD)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_last) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_ONE;
    end
  end

  // State registers; reset wins over any simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Zero-wait read mux, zero-extended, forced to 0 when not selected.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:     readdata[WIDTH-1:0]    = data_q;
        ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_q;
        ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
        ADDR_STATUS:   readdata[0]            = phase_q;
        default:       readdata               = '0;
      endcase
    end
  end

  // Blink-enabled bits follow the phase; others drive DATA directly.
  assign out_port = data_q & (~blink_q | {WIDTH{phase_q}});

endmodule

// File: doc/pio_out_blink.md
PIO_OUT_BLINK -- requirements
Module: pio_out_blink

Interface
REQ-001 Parameter WIDTH, default 10: number of output bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into DATA at reset, WIDTH bits.
REQ-003 Parameter PERIOD_W, default 24: width of the PERIOD register and blink counter, legal range 1..32.
REQ-004 clk  in  1  system clock; all state SHALL update on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  3  word address of the register being accessed.
REQ-007 chipselect  in  1  slave select; qualifies both reads and writes.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data; only bits [WIDTH-1:0] or [PERIOD_W-1:0] SHALL be used, by register.
REQ-010 readdata  out  32  read data, zero-wait (combinational from address), unused upper bits zero.
REQ-011 out_port  out  WIDTH  driven output pins.

Function
REQ-012 A write SHALL occur on a clk edge where chipselect=1 and write_n=0; no other signal combination SHALL change register state.
REQ-013 The register map SHALL be: 0 DATA (rw); 1 BLINK_EN (rw, WIDTH bits); 2 PERIOD (rw, PERIOD_W bits); 3 STATUS (ro, bit0 = phase); 4 OUTSET (wo); 5 OUTCLEAR (wo); 6-7 reserved.
REQ-014 Write to address 0 SHALL load DATA <= writedata[WIDTH-1:0] on that edge.
REQ-015 Write to address 4 SHALL load DATA <= DATA | writedata[WIDTH-1:0]; zero bits leave DATA unchanged.
REQ-016 Write to address 5 SHALL load DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-017 Writes to addresses 3, 6, 7 SHALL be ignored.
REQ-018 readdata SHALL return DATA, BLINK_EN, PERIOD, or {31'b0, phase} for addresses 0-3, and 0 for addresses 4-7, zero-extended to 32 bits, whenever chipselect=1; readdata SHALL be 0 when chipselect=0.
REQ-019 out_port[i] SHALL equal DATA[i] & (~BLINK_EN[i] | phase), combinationally from registers, so a write is visible on out_port the cycle after the write edge.
REQ-020 Blink counter cnt (PERIOD_W bits): when PERIOD!=0, cnt SHALL increment each cycle; when cnt == PERIOD-1, cnt SHALL return to 0 and phase SHALL toggle on the same edge.
REQ-021 Blinked bits SHALL therefore spend exactly PERIOD cycles in each phase, giving a full blink period of 2*PERIOD cycles; PERIOD=1 SHALL toggle phase every cycle.
REQ-022 When PERIOD==0, cnt SHALL hold 0 and phase SHALL hold 1, so blinking bits are steadily on.
REQ-023 A write to PERIOD SHALL, on the same edge, clear cnt to 0 and set phase to 1, regardless of the old count; this restarts the on-phase and prevents cnt from exceeding the new PERIOD.
REQ-024 Writes to DATA, BLINK_EN, OUTSET, or OUTCLEAR SHALL NOT affect cnt or phase.
REQ-025 The cnt==PERIOD-1 comparison SHALL be done at PERIOD_W width; wrap-around beyond 2^PERIOD_W-1 SHALL NOT occur.

Reset
REQ-026 While reset=1 at a clk edge: DATA <= RESET_VALUE, BLINK_EN <= 0, PERIOD <= 0, cnt <= 0, phase <= 1; reset SHALL take priority over a simultaneous write.
REQ-027 After reset, out_port SHALL equal RESET_VALUE[WIDTH-1:0], and readdata for addresses 0-3 SHALL read RESET_VALUE, 0, 0, 1.
REQ-028 Reset asserted mid-blink SHALL abandon the current count; no phase toggle SHALL occur on the reset edge.

Verification
REQ-029 Reset with WIDTH=10, RESET_VALUE=0x155 -> out_port=0x155; readdata at addresses 0/1/2/3 reads 0x155/0/0/1.
REQ-030 Write DATA=0x0F0, then OUTSET=0x003, then OUTCLEAR=0x010 -> DATA reads 0x0F0, then 0x0F3, then 0x0E3; out_port follows one cycle after each write; address 4/5 reads 0.
REQ-031 DATA=0x3FF, BLINK_EN=0x00F, PERIOD=4 -> out_port=0x3FF for 4 cycles, then 0x3F0 for 4 cycles, repeating; STATUS bit0 tracks phase.
REQ-032 While blinking with PERIOD=100 at cnt=60, write PERIOD=10 -> phase=1 on the next cycle; the first toggle occurs exactly 10 cycles after the write edge.
REQ-033 Write PERIOD=0 during phase 0 -> phase=1 and out_port=DATA steadily; PERIOD=1 -> out_port blinked bits toggle every cycle.
REQ-034 Assert reset on the same edge as a DATA write of 0x2AA, mid-blink -> DATA=RESET_VALUE, phase=1, cnt=0; a write with chipselect=0 or write_n=1 changes nothing.
